e_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline; sits directly downstream of the decode stage and consumes its E-stage register outputs (IRE, PC4E, RSE, RTE, EXTE, ExcCodeE, bdE). It performs E-stage operand forwarding, ALU evaluation, and multi-cycle multiply/divide with HI/LO. It also owns the E/M pipeline register that feeds the memory stage. It exports Start/Busy so the hazard unit can stall multiply/divide-dependent instructions in D.

---
 rtl/e_stage_pkg.sv | 91 +++++++++
 rtl/e_stage_md_unit.sv | 99 +++++++++
 rtl/e_stage.sv | 182 ++++++++++++++++++
 tb/tb_e_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_stage_pkg.sv
// Shared definitions for the execute stage: opcode/funct encodings,
// instruction-field helpers, exception codes, forwarding selects and the
// multiply/divide operation type.
package e_stage_pkg;

  // Primary opcodes used by the E stage.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes.
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // Exception codes; EXC_DEFAULT marks "no exception pending".
  localparam logic [4:0] EXC_DEFAULT = 5'h1F;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // Forwarding select encodings; unused codes fall back to the E value.
  localparam logic [2:0] FWD_E   = 3'd0;
  localparam logic [2:0] FWD_AO  = 3'd1;
  localparam logic [2:0] FWD_PC8 = 3'd2;
  localparam logic [2:0] FWD_WD  = 3'd3;

  // Low two funct bits of mult/multu/div/divu map directly onto this type.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] ir);
    return ir[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  // Operand forwarding mux shared by the RS and RT paths.
  function automatic logic [31:0] f_fwd(input logic [2:0]  sel,
                                        input logic [31:0] e_val,
                                        input logic [31:0] ao,
                                        input logic [31:0] pc4m,
                                        input logic [31:0] wd);
    case (sel)
      FWD_AO:  return ao;
      FWD_PC8: return pc4m + 32'd4;
      FWD_WD:  return wd;
      default: return e_val;
    endcase
  endfunction

endpackage

// File: rtl/e_stage_md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. Operands are latched on
// start; the result is written to HI/LO when the busy counter falls from
// 1 to 0. A zero divisor leaves HI/LO untouched but still runs the full
// busy period.
module md_unit
  import e_stage_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        i_start,
  input  md_op_e      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  md_op_e           r_op;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic [63:0]        w_res;
  logic               w_res_ok;

  assign w_sa   = {{32{r_a[31]}}, r_a};
  assign w_sb   = {{32{r_b[31]}}, r_b};
  assign o_busy = (r_cnt != '0);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // Result of the latched operation as {HI, LO}; invalid for a zero divisor.
  always_comb begin
    w_res    = {r_hi, r_lo};
    w_res_ok = 1'b1;
    case (r_op)
      MD_MULT:  w_res = w_sa * w_sb;
      MD_MULTU: w_res = {32'd0, r_a} * {32'd0, r_b};
      MD_DIV: begin
        if (r_b != 32'd0) begin
          w_res = {$signed(r_a) % $signed(r_b), $signed(r_a) / $signed(r_b)};
        end else begin
          w_res_ok = 1'b0;
        end
      end
      default: begin
        if (r_b != 32'd0) begin
          w_res = {r_a % r_b, r_a / r_b};
        end else begin
          w_res_ok = 1'b0;
        end
      end
    endcase
  end

  // Counter, operand latches and HI/LO; completion overrides mthi/mtlo.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MD_MULT;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (i_start) begin
        r_cnt <= (i_op == MD_DIV || i_op == MD_DIVU) ? DIV_LD : MULT_LD;
        r_a   <= i_rs;
        r_b   <= i_rt;
        r_op  <= i_op;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (i_mthi) r_hi <= i_rs;
      if (i_mtlo) r_lo <= i_rs;
      if (r_cnt == CNT_ONE && w_res_ok) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
    end
  end

endmodule

// File: rtl/e_stage.sv
// Execute stage: operand forwarding, combinational ALU, multiply/divide
// unit with HI/LO, and the E/M pipeline register.
// Optional macro E_OV_EXC_EN: raise Ov on add/addi/sub signed overflow and
// AdEL/AdES on misaligned lw/sw (only when no earlier exception is pending).
module e_stage #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRE,
  input  logic [31:0] PC4E,
  input  logic [31:0] RSE,
  input  logic [31:0] RTE,
  input  logic [31:0] EXTE,
  input  logic [6:2]  ExcCodeE,
  input  logic        bdE,
  input  logic [2:0]  Forward_RS_E_Sel,
  input  logic [2:0]  Forward_RT_E_Sel,
  input  logic [31:0] AO,
  input  logic [31:0] PC4fromM,
  input  logic [31:0] MUX_RF_WD_OUT,
  input  logic        exp_in,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] IRM,
  output logic [31:0] PC4M,
  output logic [31:0] AOM,
  output logic [31:0] RTM,
  output logic [6:2]  ExcCodeM,
  output logic        bdM
);
  import e_stage_pkg::*;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic        w_rtype;
  logic [31:0] w_rsf;
  logic [31:0] w_rtf;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_aom_next;
  logic [4:0]  w_exc_next;
  logic        w_is_md;
  logic        w_mthi;
  logic        w_mtlo;
  md_op_e      w_md_op;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  assign w_op    = f_op(IRE);
  assign w_funct = f_funct(IRE);
  assign w_shamt = f_shamt(IRE);
  assign w_rtype = (w_op == OP_RTYPE);

  assign w_rsf = f_fwd(Forward_RS_E_Sel, RSE, AO, PC4fromM, MUX_RF_WD_OUT);
  assign w_rtf = f_fwd(Forward_RT_E_Sel, RTE, AO, PC4fromM, MUX_RF_WD_OUT);
  assign w_a   = w_rsf;
  assign w_b   = w_rtype ? w_rtf : EXTE;

  assign w_is_md = w_rtype && (w_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign w_md_op = md_op_e'(w_funct[1:0]);
  assign Start   = w_is_md && (ExcCodeE == EXC_DEFAULT) && !exp_in && !Busy;
  assign w_mthi  = w_rtype && (w_funct == F_MTHI) && !Busy && !exp_in;
  assign w_mtlo  = w_rtype && (w_funct == F_MTLO) && !Busy && !exp_in;

  md_unit #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md (
    .i_clk  (Clk),
    .i_srst (Reset),
    .i_start(Start),
    .i_op   (w_md_op),
    .i_rs   (w_rsf),
    .i_rt   (w_rtf),
    .i_mthi (w_mthi),
    .i_mtlo (w_mtlo),
    .o_busy (Busy),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  // ALU: R-type uses the forwarded RT as B, I-type uses the immediate.
  always_comb begin
    w_alu = w_a + w_b;
    if (w_rtype) begin
      case (w_funct)
        F_ADD, F_ADDU: w_alu = w_a + w_b;
        F_SUB, F_SUBU: w_alu = w_a - w_b;
        F_AND:  w_alu = w_a & w_b;
        F_OR:   w_alu = w_a | w_b;
        F_XOR:  w_alu = w_a ^ w_b;
        F_NOR:  w_alu = ~(w_a | w_b);
        F_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
        F_SLTU: w_alu = {31'd0, w_a < w_b};
        F_SLL:  w_alu = w_rtf << w_shamt;
        F_SRL:  w_alu = w_rtf >> w_shamt;
        F_SRA:  w_alu = $signed(w_rtf) >>> w_shamt;
        F_SLLV: w_alu = w_rtf << w_a[4:0];
        F_SRLV: w_alu = w_rtf >> w_a[4:0];
        F_SRAV: w_alu = $signed(w_rtf) >>> w_a[4:0];
        default: w_alu = 32'd0;
      endcase
    end else begin
      case (w_op)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: w_alu = w_a + w_b;
        OP_SLTI:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
        OP_SLTIU: w_alu = {31'd0, w_a < w_b};
        OP_ANDI:  w_alu = w_a & w_b;
        OP_ORI:   w_alu = w_a | w_b;
        OP_XORI:  w_alu = w_a ^ w_b;
        OP_LUI:   w_alu = {w_b[15:0], 16'h0000};
        default:  w_alu = 32'd0;
      endcase
    end
  end

  // AOM source: HI/LO for mfhi/mflo, ALU result otherwise.
  always_comb begin
    w_aom_next = w_alu;
    if (w_rtype && w_funct == F_MFHI) w_aom_next = w_hi;
    if (w_rtype && w_funct == F_MFLO) w_aom_next = w_lo;
  end

`ifdef E_OV_EXC_EN
  logic w_ov;
  logic w_is_add;
  logic w_is_sub;

  assign w_is_add = (w_rtype && w_funct == F_ADD) || (w_op == OP_ADDI);
  assign w_is_sub = w_rtype && w_funct == F_SUB;

  // Signed overflow: same-sign add or opposite-sign sub flipping the sign.
  always_comb begin
    w_ov = 1'b0;
    if (w_is_add) w_ov = (w_a[31] == w_b[31]) && (w_alu[31] != w_a[31]);
    if (w_is_sub) w_ov = (w_a[31] != w_b[31]) && (w_alu[31] != w_a[31]);
  end

  // New exceptions only when nothing earlier is already pending.
  always_comb begin
    w_exc_next = ExcCodeE;
    if (ExcCodeE == EXC_DEFAULT) begin
      if (w_ov) begin
        w_exc_next = EXC_OV;
      end else if (w_op == OP_LW && w_alu[1:0] != 2'b00) begin
        w_exc_next = EXC_ADEL;
      end else if (w_op == OP_SW && w_alu[1:0] != 2'b00) begin
        w_exc_next = EXC_ADES;
      end
    end
  end
`else
  // Without exception detection the incoming code passes straight through.
  always_comb begin
    w_exc_next = ExcCodeE;
  end
`endif

  // E/M pipeline register; an exception flushes it like reset.
  always_ff @(posedge Clk) begin
    if (Reset || exp_in) begin
      IRM      <= 32'd0;
      PC4M     <= 32'd0;
      AOM      <= 32'd0;
      RTM      <= 32'd0;
      ExcCodeM <= EXC_DEFAULT;
      bdM      <= 1'b0;
    end else begin
      IRM      <= IRE;
      PC4M     <= PC4E;
      AOM      <= w_aom_next;
      RTM      <= w_rtf;
      ExcCodeM <= w_exc_next;
      bdM      <= bdE;
    end
  end

endmodule

// File: tb/tb_e_stage.sv
// Directed testbench for e_stage: reset, forwarding, ALU, multiply/divide
// timing and HI/LO, exception flush, and optional E_OV_EXC_EN exceptions.
module tb_e_stage;

  localparam logic [4:0] EXC_NONE = 5'h1F;
`ifdef E_OV_EXC_EN
  localparam logic [4:0] X_OV   = 5'd12;
  localparam logic [4:0] X_ADEL = 5'd4;
  localparam logic [4:0] X_ADES = 5'd5;
`else
  localparam logic [4:0] X_OV   = 5'h1F;
  localparam logic [4:0] X_ADEL = 5'h1F;
  localparam logic [4:0] X_ADES = 5'h1F;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] IRE, PC4E, RSE, RTE, EXTE;
  logic [6:2]  ExcCodeE;
  logic        bdE;
  logic [2:0]  Forward_RS_E_Sel, Forward_RT_E_Sel;
  logic [31:0] AO, PC4fromM, MUX_RF_WD_OUT;
  logic        exp_in;
  logic        Start, Busy;
  logic [31:0] IRM, PC4M, AOM, RTM;
  logic [6:2]  ExcCodeM;
  logic        bdM;

  int n_assert = 0;
  int n_fail   = 0;
  logic start_seen;

  e_stage dut (
    .Clk(clk), .Reset(Reset), .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE),
    .EXTE(EXTE), .ExcCodeE(ExcCodeE), .bdE(bdE),
    .Forward_RS_E_Sel(Forward_RS_E_Sel), .Forward_RT_E_Sel(Forward_RT_E_Sel),
    .AO(AO), .PC4fromM(PC4fromM), .MUX_RF_WD_OUT(MUX_RF_WD_OUT),
    .exp_in(exp_in), .Start(Start), .Busy(Busy), .IRM(IRM), .PC4M(PC4M),
    .AOM(AOM), .RTM(RTM), .ExcCodeM(ExcCodeM), .bdM(bdM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [5:0] funct, input logic [4:0] sh);
    return {6'h00, 15'h0000, sh, funct};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to E for one cycle; Start is sampled before the edge.
  task automatic run(input string name, input logic [31:0] ir, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] ext);
    IRE = ir; RSE = rs; RTE = rt; EXTE = ext;
    #1;
    start_seen = Start;
    tick();
    $display("step %s IR=%h RS=%h RT=%h EXT=%h -> AOM=%h RTM=%h Exc=%0d Busy=%0b",
             name, ir, rs, rt, ext, AOM, RTM, ExcCodeM, Busy);
  endtask

  task automatic idle(input int n);
    IRE = 32'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expect Busy for exactly n cycles after a start edge, then low.
  task automatic busy_run(input string tag, input int n);
    IRE = 32'd0;
    for (int i = 0; i < n; i++) begin
      chk(tag, {31'd0, Busy}, 32'd1);
      tick();
    end
    chk(tag, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; IRE = r_ins(6'h21, 5'd0); PC4E = 32'h3000; RSE = 32'd1; RTE = 32'd2;
    EXTE = 32'd0; ExcCodeE = EXC_NONE; bdE = 1'b1; Forward_RS_E_Sel = 3'd0;
    Forward_RT_E_Sel = 3'd0; AO = 32'd0; PC4fromM = 32'd0; MUX_RF_WD_OUT = 32'd0;
    exp_in = 1'b0;
    tick(); tick();
    chk("rst_irm", IRM, 32'd0);
    chk("rst_aom", AOM, 32'd0);
    chk("rst_exc", {27'd0, ExcCodeM}, {27'd0, EXC_NONE});
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_bdm", {31'd0, bdM}, 32'd0);
    Reset = 1'b0;

    // Basic pass-through and ALU.
    run("addu", r_ins(6'h21, 5'd0), 32'd3, 32'd5, 32'd0);
    chk("addu_aom", AOM, 32'd8);
    chk("addu_irm", IRM, 32'h00000021);
    chk("addu_pc4m", PC4M, 32'h3000);
    chk("addu_rtm", RTM, 32'd5);
    chk("addu_bdm", {31'd0, bdM}, 32'd1);
    chk("addu_exc", {27'd0, ExcCodeM}, {27'd0, EXC_NONE});
    bdE = 1'b0;

    // Forwarding paths.
    Forward_RS_E_Sel = 3'd1; AO = 32'h10;
    run("fwd_ao", r_ins(6'h21, 5'd0), 32'd0, 32'd5, 32'd0);
    chk("fwd_ao", AOM, 32'h15);
    Forward_RS_E_Sel = 3'd2; PC4fromM = 32'h3004;
    run("fwd_pc8", r_ins(6'h21, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("fwd_pc8", AOM, 32'h3008);
    Forward_RS_E_Sel = 3'd3; Forward_RT_E_Sel = 3'd3; MUX_RF_WD_OUT = 32'h100;
    run("fwd_wd", r_ins(6'h21, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("fwd_wd", AOM, 32'h200);
    chk("fwd_wd_rtm", RTM, 32'h100);
    Forward_RS_E_Sel = 3'd5; Forward_RT_E_Sel = 3'd7;
    run("fwd_5", r_ins(6'h21, 5'd0), 32'd7, 32'd1, 32'd0);
    chk("fwd_sel5", AOM, 32'd8);
    chk("fwd_sel7_rtm", RTM, 32'd1);
    Forward_RS_E_Sel = 3'd0; Forward_RT_E_Sel = 3'd0;

    run("subu", r_ins(6'h23, 5'd0), 32'd5, 32'd7, 32'd0);
    chk("subu", AOM, 32'hFFFFFFFE);
    run("slt", r_ins(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("slt", AOM, 32'd1);
    run("sltu", r_ins(6'h2B, 5'd0), 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("sltu", AOM, 32'd0);
    run("sra", r_ins(6'h03, 5'd4), 32'd0, 32'h80000000, 32'd0);
    chk("sra", AOM, 32'hF8000000);
    run("srl", r_ins(6'h02, 5'd4), 32'd0, 32'h80000000, 32'd0);
    chk("srl", AOM, 32'h08000000);
    run("sllv", r_ins(6'h04, 5'd0), 32'h24, 32'd1, 32'd0);
    chk("sllv", AOM, 32'h10);
    run("srav", r_ins(6'h07, 5'd0), 32'd1, 32'h80000000, 32'd0);
    chk("srav", AOM, 32'hC0000000);
    run("nor", r_ins(6'h27, 5'd0), 32'hF0F0F0F0, 32'h0F0F0F00, 32'd0);
    chk("nor", AOM, 32'h0000000F);
    run("lui", i_ins(6'h0F), 32'd0, 32'hDEAD, 32'h1234);
    chk("lui", AOM, 32'h12340000);
    chk("lui_rtm", RTM, 32'hDEAD);
    run("ori", i_ins(6'h0D), 32'h1200, 32'hDEAD, 32'h34);
    chk("ori", AOM, 32'h1234);
    run("xori", i_ins(6'h0E), 32'hFF, 32'd0, 32'h0F);
    chk("xori", AOM, 32'hF0);
    run("slti", i_ins(6'h0A), 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF);
    chk("slti", AOM, 32'd1);
    run("sltiu", i_ins(6'h0B), 32'd5, 32'd0, 32'hFFFFFFFF);
    chk("sltiu", AOM, 32'd1);

    // Overflow and alignment exceptions (default code when the macro is off).
    run("add_ov", r_ins(6'h20, 5'd0), 32'h7FFFFFFF, 32'd1, 32'd0);
    chk("add_ov_aom", AOM, 32'h80000000);
    chk("add_ov_exc", {27'd0, ExcCodeM}, {27'd0, X_OV});
    run("addi_ov", i_ins(6'h08), 32'h7FFFFFFF, 32'd0, 32'd1);
    chk("addi_ov_exc", {27'd0, ExcCodeM}, {27'd0, X_OV});
    run("sub_ov", r_ins(6'h22, 5'd0), 32'h80000000, 32'd1, 32'd0);
    chk("sub_ov_aom", AOM, 32'h7FFFFFFF);
    chk("sub_ov_exc", {27'd0, ExcCodeM}, {27'd0, X_OV});
    run("addu_noov", r_ins(6'h21, 5'd0), 32'h7FFFFFFF, 32'd1, 32'd0);
    chk("addu_noov_exc", {27'd0, ExcCodeM}, {27'd0, EXC_NONE});
    run("lw_mis", i_ins(6'h23), 32'd0, 32'd0, 32'd2);
    chk("lw_mis_aom", AOM, 32'd2);
    chk("lw_mis_exc", {27'd0, ExcCodeM}, {27'd0, X_ADEL});
    run("sw_mis", i_ins(6'h2B), 32'h100, 32'd0, 32'd1);
    chk("sw_mis_exc", {27'd0, ExcCodeM}, {27'd0, X_ADES});
    run("lw_ok", i_ins(6'h23), 32'h100, 32'd0, 32'd4);
    chk("lw_ok_exc", {27'd0, ExcCodeM}, {27'd0, EXC_NONE});
    ExcCodeE = 5'd10;
    run("add_prior", r_ins(6'h20, 5'd0), 32'h7FFFFFFF, 32'd1, 32'd0);
    chk("add_prior_exc", {27'd0, ExcCodeM}, 32'd10);
    IRE = r_ins(6'h18, 5'd0); #1;
    chk("start_excpend", {31'd0, Start}, 32'd0);
    ExcCodeE = EXC_NONE;

    // mult -3 * 7.
    run("mult", r_ins(6'h18, 5'd0), 32'hFFFFFFFD, 32'd7, 32'd0);
    chk("mult_start", {31'd0, start_seen}, 32'd1);
    busy_run("mult_busy", 5);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("mult_hi", AOM, 32'hFFFFFFFF);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("mult_lo", AOM, 32'hFFFFFFEB);

    // multu 0xFFFFFFFF * 2.
    run("multu", r_ins(6'h19, 5'd0), 32'hFFFFFFFF, 32'd2, 32'd0);
    busy_run("multu_busy", 5);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("multu_hi", AOM, 32'd1);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("multu_lo", AOM, 32'hFFFFFFFE);

    // div -7 / 2, with Start held low while busy.
    run("div", r_ins(6'h1A, 5'd0), 32'hFFFFFFF9, 32'd2, 32'd0);
    chk("div_start", {31'd0, start_seen}, 32'd1);
    IRE = r_ins(6'h1A, 5'd0); #1;
    chk("start_while_busy", {31'd0, Start}, 32'd0);
    busy_run("div_busy", 10);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("div_lo", AOM, 32'hFFFFFFFD);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("div_hi", AOM, 32'hFFFFFFFF);

    // mthi/mtlo, then divide by zero leaves them.
    run("mthi", r_ins(6'h11, 5'd0), 32'h11111111, 32'd0, 32'd0);
    run("mtlo", r_ins(6'h13, 5'd0), 32'h22222222, 32'd0, 32'd0);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("mthi", AOM, 32'h11111111);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("mtlo", AOM, 32'h22222222);
    run("div0", r_ins(6'h1A, 5'd0), 32'd5, 32'd0, 32'd0);
    busy_run("div0_busy", 10);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("div0_hi", AOM, 32'h11111111);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("div0_lo", AOM, 32'h22222222);

    // mthi killed by exp_in.
    exp_in = 1'b1;
    run("mthi_exp", r_ins(6'h11, 5'd0), 32'h0BAD0BAD, 32'd0, 32'd0);
    exp_in = 1'b0;
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("mthi_exp_hi", AOM, 32'h11111111);

    // exp_in with a mult start: suppressed, E/M flushed.
    exp_in = 1'b1; PC4E = 32'h4000; bdE = 1'b1;
    run("mult_exp", r_ins(6'h18, 5'd0), 32'hFFFFFFFD, 32'd7, 32'd0);
    chk("mult_exp_start", {31'd0, start_seen}, 32'd0);
    chk("mult_exp_busy", {31'd0, Busy}, 32'd0);
    chk("mult_exp_irm", IRM, 32'd0);
    chk("mult_exp_pc4m", PC4M, 32'd0);
    chk("mult_exp_rtm", RTM, 32'd0);
    chk("mult_exp_bdm", {31'd0, bdM}, 32'd0);
    chk("mult_exp_exc", {27'd0, ExcCodeM}, {27'd0, EXC_NONE});
    exp_in = 1'b0; bdE = 1'b0;

    // exp_in during an in-flight divu does not abort it.
    run("divu", r_ins(6'h1B, 5'd0), 32'd100, 32'd7, 32'd0);
    idle(1);
    exp_in = 1'b1;
    run("flush", r_ins(6'h21, 5'd0), 32'd1, 32'd1, 32'd0);
    chk("flush_irm", IRM, 32'd0);
    chk("flush_aom", AOM, 32'd0);
    exp_in = 1'b0;
    chk("divu_busy_after_exp", {31'd0, Busy}, 32'd1);
    idle(8);
    chk("divu_done", {31'd0, Busy}, 32'd0);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("divu_lo", AOM, 32'd14);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("divu_hi", AOM, 32'd2);

    // Reset mid-operation clears Busy and HI/LO.
    run("mult", r_ins(6'h18, 5'd0), 32'd2, 32'd3, 32'd0);
    idle(2);
    Reset = 1'b1;
    tick();
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    idle(6);
    chk("rst_mid_idle", {31'd0, Busy}, 32'd0);
    run("mfhi", r_ins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("rst_mid_hi", AOM, 32'd0);
    run("mflo", r_ins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    chk("rst_mid_lo", AOM, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
